// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage in-order pipeline.
// Issues byte/half/word loads and stores on a req/ack data port.
// Stalls upstream stages while an access is outstanding.
// Holds the MEM/WB pipeline register that feeds writeback.
module mem_stage #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        validm,
    input  logic        regWrtm,
    input  logic        memWrtm,
    input  logic [1:0]  rsltSrcm,
    input  logic [2:0]  funct3m,
    input  logic [4:0]  rdm,
    input  logic [31:0] aluRsltm,
    input  logic [31:0] wrtDm,
    input  logic [31:0] pc4m,
    output logic        dReq,
    output logic        dWe,
    output logic [31:0] dAddr,
    output logic [3:0]  dBe,
    output logic [31:0] dWData,
    input  logic [31:0] dRData,
    input  logic        dAck,
    output logic        stallM,
    output logic        regWrtw,
    output logic [1:0]  rsltSrcw,
    output logic [4:0]  rdw,
    output logic [31:0] aluRsltw,
    output logic [31:0] rdDw,
    output logic [31:0] pc4w,
    output logic [1:0]  excw
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;

    logic        regWrtw_q;
    logic [1:0]  rsltSrcw_q;
    logic [4:0]  rdw_q;
    logic [31:0] aluRsltw_q;
    logic [31:0] rdDw_q;
    logic [31:0] pc4w_q;
    logic [1:0]  excw_q;

    logic [1:0]  a;
    logic        is_byte, is_half, is_word;
    logic        access, misal, timeout;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign a       = aluRsltm[1:0];
    assign is_byte = (funct3m[1:0] == 2'b00);
    assign is_half = (funct3m[1:0] == 2'b01);
    assign is_word = !is_byte && !is_half;

    assign access = validm && (memWrtm || (rsltSrcm == 2'b01));
    assign misal  = access && ((is_half && a[0]) || (is_word && (a != 2'b00)));

    // The state term covers every encoding; it is kept so the request is tied to the FSM.
    assign dReq    = !rst && access && !misal && (state_q == S_IDLE || state_q == S_WAIT);
    // A same-cycle acknowledge takes precedence over the timeout.
    assign timeout = dReq && !dAck && (state_q == S_WAIT) && (waitCnt_q == WAIT_LAST);
    assign stallM  = dReq && !dAck && !timeout;

    assign dWe   = memWrtm;
    assign dAddr = {aluRsltm[31:2], 2'b00};

    // Byte enables and lane-replicated store data from access size and offset.
    always_comb begin
        dBe    = 4'b1111;
        dWData = wrtDm;
        if (is_byte) begin
            dBe    = 4'b0001 << a;
            dWData = {4{wrtDm[7:0]}};
        end else if (is_half) begin
            dBe    = 4'b0011 << a;
            dWData = {2{wrtDm[15:0]}};
        end
    end

    // Select the addressed lane of the read data and sign/zero extend it.
    always_comb begin
        byte_sel = dRData[7:0];
        case (a)
            2'b00: byte_sel = dRData[7:0];
            2'b01: byte_sel = dRData[15:8];
            2'b10: byte_sel = dRData[23:16];
            2'b11: byte_sel = dRData[31:24];
            default: byte_sel = dRData[7:0];
        endcase
        half_sel = a[1] ? dRData[31:16] : dRData[15:0];
        case (funct3m)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = dRData;
        endcase
    end

    // Next state of the access FSM and its wait counter.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            S_IDLE: begin
                waitCnt_d = '0;
                if (dReq && !dAck) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!dReq || dAck || timeout) begin
                    state_d   = S_IDLE;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                waitCnt_d = '0;
            end
        endcase
    end

    // FSM state plus the MEM/WB register, with bubble/exception insertion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            waitCnt_q  <= '0;
            regWrtw_q  <= 1'b0;
            rsltSrcw_q <= '0;
            rdw_q      <= '0;
            aluRsltw_q <= '0;
            rdDw_q     <= '0;
            pc4w_q     <= '0;
            excw_q     <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            if (stallM) begin
                regWrtw_q <= 1'b0;
                excw_q    <= 2'b00;
            end else if (timeout) begin
                regWrtw_q <= 1'b0;
                excw_q    <= 2'b10;
            end else if (misal) begin
                regWrtw_q <= 1'b0;
                excw_q    <= 2'b01;
            end else if (!validm) begin
                regWrtw_q <= 1'b0;
                excw_q    <= 2'b00;
            end else begin
                regWrtw_q  <= regWrtm;
                rsltSrcw_q <= rsltSrcm;
                rdw_q      <= rdm;
                aluRsltw_q <= aluRsltm;
                rdDw_q     <= load_ext;
                pc4w_q     <= pc4m;
                excw_q     <= 2'b00;
            end
        end
    end

    assign regWrtw  = regWrtw_q;
    assign rsltSrcw = rsltSrcw_q;
    assign rdw      = rdw_q;
    assign aluRsltw = aluRsltw_q;
    assign rdDw     = rdDw_q;
    assign pc4w     = pc4w_q;
    assign excw     = excw_q;

endmodule
